fetch_unit: RTL and testbench

Parametrised instruction-fetch front end, successor to the single-queue fetch stage. It owns the PC, requests instructions from the memory controller, and predecodes each returned word. It predicts branches with a 2-bit bimodal table trained at ROB commit, and buffers fetched instructions in a configurable-depth queue. Dispatch logic for the ROB, RS and LSB pops the queue; a ROB mispredict flushes it and redirects the PC.

---
 rtl/fetch_unit.sv | 158 +++++++++++++++
 tb/tb_fetch_unit.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end with predecode, bimodal BHT and issue queue
// Ports: clk_in/rst_in/rdy_in control; mem_* fetch handshake to the memory controller;
// issue_* head of the instruction queue toward dispatch; rob_* branch training and redirect;
// roll_back_out registered flush pulse to the other units.
module fetch_unit #(
  parameter int          ISQ_DEPTH_LOG  = 4,
  parameter int          BHT_INDEX_BITS = 6,
  parameter logic [31:0] RESET_PC       = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        mem_idle,
  input  logic        mem_done,
  input  logic [31:0] mem_inst,
  output logic        mem_req,
  output logic [31:0] mem_pc,
  input  logic        issue_ready,
  output logic        issue_valid,
  output logic [31:0] issue_inst,
  output logic [31:0] issue_pc,
  output logic        issue_pred_taken,
  input  logic        rob_branch_commit,
  input  logic [31:0] rob_branch_pc,
  input  logic        rob_branch_taken,
  input  logic        rob_mispredict,
  input  logic [31:0] rob_target_pc,
  output logic        roll_back_out
);
  localparam int DEPTH = 1 << ISQ_DEPTH_LOG;
  localparam int BHT_N = 1 << BHT_INDEX_BITS;
  localparam logic [ISQ_DEPTH_LOG:0] FULL = (ISQ_DEPTH_LOG+1)'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]               state_q, state_d;
  logic [31:0]              pc_q, pc_d;
  logic [ISQ_DEPTH_LOG-1:0] head_q, head_d, tail_q, tail_d;
  logic [ISQ_DEPTH_LOG:0]   count_q, count_d;
  logic                     roll_back_q;
  logic [1:0]               bht_q [BHT_N];
  logic [31:0]              inst_mem_q [DEPTH];
  logic [31:0]              pc_mem_q [DEPTH];
  logic                     pred_mem_q [DEPTH];

  logic                      fetch_go, push, pop, pred;
  logic [31:0]               imm_j, imm_b, next_pc;
  logic [BHT_INDEX_BITS-1:0] fetch_idx, commit_idx;
  logic                      unused_pc_bits;

  assign fetch_idx  = pc_q[BHT_INDEX_BITS+1:2];
  assign commit_idx = rob_branch_pc[BHT_INDEX_BITS+1:2];
  // Bits of the committing PC outside the table index do not select a counter.
  assign unused_pc_bits = ^{rob_branch_pc[31:BHT_INDEX_BITS+2], rob_branch_pc[1:0]};

  assign imm_j = {{12{mem_inst[31]}}, mem_inst[19:12], mem_inst[20], mem_inst[30:21], 1'b0};
  assign imm_b = {{20{mem_inst[31]}}, mem_inst[7], mem_inst[30:25], mem_inst[11:8], 1'b0};

  // Predecode: JAL always redirects, conditional branches follow the counter MSB,
  // everything else (JALR included) falls through.
  always_comb begin
    next_pc = pc_q + 32'd4;
    pred    = 1'b0;
    case (mem_inst[6:0])
      7'b1101111: begin
        next_pc = pc_q + imm_j;
        pred    = 1'b1;
      end
      7'b1100011: begin
        pred = bht_q[fetch_idx][1];
        if (pred) next_pc = pc_q + imm_b;
      end
      default: ;
    endcase
  end

  // A request is only made with a free slot, so a push can never overflow.
  assign fetch_go = rdy_in && !rst_in && !rob_mispredict && (state_q == S_IDLE) &&
                    mem_idle && (count_q < FULL);
  assign push     = (state_q == S_WAIT) && mem_done && !rob_mispredict;
  assign pop      = issue_valid && issue_ready && !rob_mispredict;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rob_mispredict) begin
      pc_d    = rob_target_pc;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      // An outstanding fetch still owes us one mem_done; swallow it in DROP.
      state_d = (state_q != S_IDLE && !mem_done) ? S_DROP : S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (fetch_go) state_d = S_WAIT;
        S_WAIT: if (mem_done) begin
          state_d = S_IDLE;
          pc_d    = next_pc;
        end
        S_DROP: if (mem_done) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      roll_back_q <= 1'b0;
      for (int i = 0; i < BHT_N; i++) bht_q[i] <= 2'b01;
    end else if (rdy_in) begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      roll_back_q <= rob_mispredict;
      if (rob_branch_commit) begin
        if (rob_branch_taken && bht_q[commit_idx] != 2'b11)
          bht_q[commit_idx] <= bht_q[commit_idx] + 2'd1;
        else if (!rob_branch_taken && bht_q[commit_idx] != 2'b00)
          bht_q[commit_idx] <= bht_q[commit_idx] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && push) begin
      inst_mem_q[tail_q] <= mem_inst;
      pc_mem_q[tail_q]   <= pc_q;
      pred_mem_q[tail_q] <= pred;
    end
  end

  assign mem_req          = fetch_go;
  assign mem_pc           = pc_q;
  assign issue_valid      = (count_q != '0);
  assign issue_inst       = inst_mem_q[head_q];
  assign issue_pc         = pc_mem_q[head_q];
  assign issue_pred_taken = pred_mem_q[head_q];
  assign roll_back_out    = roll_back_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;
  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        mem_idle = 1'b0;
  logic        mem_done = 1'b0;
  logic [31:0] mem_inst = 32'h0;
  logic        mem_req;
  logic [31:0] mem_pc;
  logic        issue_ready = 1'b0;
  logic        issue_valid;
  logic [31:0] issue_inst;
  logic [31:0] issue_pc;
  logic        issue_pred_taken;
  logic        rob_branch_commit = 1'b0;
  logic [31:0] rob_branch_pc = 32'h0;
  logic        rob_branch_taken = 1'b0;
  logic        rob_mispredict = 1'b0;
  logic [31:0] rob_target_pc = 32'h0;
  logic        roll_back_out;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] JAL_M8 = 32'hFF9FF06F;   // jal x0, -8
  localparam logic [31:0] BEQ_P16 = 32'h00000863;  // beq x0, x0, +16

  fetch_unit #(.ISQ_DEPTH_LOG(4), .BHT_INDEX_BITS(6), .RESET_PC(32'h0)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .mem_idle(mem_idle), .mem_done(mem_done), .mem_inst(mem_inst),
    .mem_req(mem_req), .mem_pc(mem_pc),
    .issue_ready(issue_ready), .issue_valid(issue_valid), .issue_inst(issue_inst),
    .issue_pc(issue_pc), .issue_pred_taken(issue_pred_taken),
    .rob_branch_commit(rob_branch_commit), .rob_branch_pc(rob_branch_pc),
    .rob_branch_taken(rob_branch_taken), .rob_mispredict(rob_mispredict),
    .rob_target_pc(rob_target_pc), .roll_back_out(roll_back_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_miss = 0;
  int          req_cnt = 0;
  int          mem_lat = 0;
  logic [31:0] last_req_pc = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h20:  return JAL_M8;
      32'h40:  return BEQ_P16;
      default: return NOP;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic exp_push(input logic [31:0] inst, input logic [31:0] pc, input logic pred);
    exp_t e;
    e.inst = inst;
    e.pc   = pc;
    e.pred = pred;
    exp_q.push_back(e);
  endtask

  // Memory controller model: answers each request after mem_lat idle cycles.
  initial begin
    bit          outstanding = 0;
    int          wait_cnt = 0;
    logic [31:0] addr = 32'h0;
    forever begin
      @(negedge clk_in);
      if (mem_req === 1'b1) begin
        chk("single_outstanding", 32'(outstanding), 32'd0);
        outstanding = 1;
        addr        = mem_pc;
        last_req_pc = mem_pc;
        wait_cnt    = mem_lat;
        req_cnt++;
      end
      @(posedge clk_in);
      #1;
      mem_done = 1'b0;
      if (outstanding) begin
        if (wait_cnt == 0) begin
          mem_done    = 1'b1;
          mem_inst    = imem(addr);
          outstanding = 0;
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  // Monitor: every entry accepted downstream is checked against the scoreboard.
  always @(negedge clk_in) begin
    if (issue_valid === 1'b1 && issue_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_issue: got pc %h expected no entry", issue_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("issue_inst", issue_inst, e.inst);
        chk("issue_pc", issue_pc, e.pc);
        chk("issue_pred_taken", 32'(issue_pred_taken), 32'(e.pred));
      end
    end
  end

  task automatic req_wait(input int n);
    int target;
    bit hit;
    target   = req_cnt + n;
    hit      = 0;
    mem_idle = 1'b1;
    for (int i = 0; i < 400 && !hit; i++) begin
      tick(1);
      if (req_cnt >= target) hit = 1;
    end
    mem_idle = 1'b0;
    chk("fetch_requests_seen", 32'(hit), 32'd1);
  endtask

  task automatic fetch_n(input int n);
    req_wait(n);
    tick(2 + mem_lat);
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    issue_ready = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk_in);
      if (issue_valid === 1'b0) ok = 1;
    end
    @(posedge clk_in);
    #1;
    chk("queue_drained", 32'(ok), 32'd1);
  endtask

  task automatic redirect(input logic [31:0] t);
    rob_mispredict = 1'b1;
    rob_target_pc  = t;
    tick(1);
    rob_mispredict    = 1'b0;
    rob_branch_commit = 1'b0;
    exp_q.delete();
    @(negedge clk_in);
    chk("roll_back_pulse", 32'(roll_back_out), 32'd1);
    chk("flush_empty", 32'(issue_valid), 32'd0);
    @(posedge clk_in);
    #1;
    @(negedge clk_in);
    chk("roll_back_single", 32'(roll_back_out), 32'd0);
    @(posedge clk_in);
    #1;
  endtask

  task automatic commit(input logic taken);
    rob_branch_commit = 1'b1;
    rob_branch_pc     = 32'h40;
    rob_branch_taken  = taken;
    tick(1);
    rob_branch_commit = 1'b0;
  endtask

  task automatic refetch_beq(input logic pred);
    redirect(32'h40);
    exp_push(BEQ_P16, 32'h40, pred);
    exp_push(NOP, pred ? 32'h50 : 32'h44, 1'b0);
    fetch_n(2);
    drain();
  endtask

  initial begin
    int base;
    tick(3);
    rst_in = 1'b0;
    @(negedge clk_in);
    chk("rst_issue_valid", 32'(issue_valid), 32'd0);
    chk("rst_roll_back", 32'(roll_back_out), 32'd0);
    chk("rst_mem_pc", mem_pc, 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    @(posedge clk_in);
    #1;

    // Stalled pipeline: no request while rdy_in is low.
    rdy_in = 1'b0;
    mem_idle = 1'b1;
    base = req_cnt;
    @(negedge clk_in);
    chk("rdy_low_mem_req", 32'(mem_req), 32'd0);
    tick(3);
    chk("rdy_low_no_fetch", 32'(req_cnt - base), 32'd0);
    mem_idle = 1'b0;
    rdy_in = 1'b1;

    // Sequential NOP stream from reset.
    issue_ready = 1'b1;
    for (int i = 0; i < 6; i++) exp_push(NOP, 32'(i * 4), 1'b0);
    fetch_n(6);
    drain();

    // Fill the queue with dispatch stalled; the JAL at 0x20 loops back to 0x18.
    issue_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      exp_push(NOP, 32'h18, 1'b0);
      exp_push(NOP, 32'h1C, 1'b0);
      exp_push(JAL_M8, 32'h20, 1'b1);
    end
    exp_push(NOP, 32'h18, 1'b0);
    base = req_cnt;
    mem_idle = 1'b1;
    tick(60);
    chk("fill_exactly_16", 32'(req_cnt - base), 32'd16);
    chk("fill_issue_valid", 32'(issue_valid), 32'd1);
    exp_push(NOP, 32'h1C, 1'b0);
    exp_push(JAL_M8, 32'h20, 1'b1);
    exp_push(NOP, 32'h18, 1'b0);
    exp_push(NOP, 32'h1C, 1'b0);
    issue_ready = 1'b1;
    req_wait(4);
    tick(2);
    drain();

    // Bimodal training on the BEQ at 0x40.
    refetch_beq(1'b0);
    commit(1'b1);
    commit(1'b1);
    refetch_beq(1'b1);
    commit(1'b1);
    commit(1'b0);
    refetch_beq(1'b1);
    for (int i = 0; i < 4; i++) commit(1'b0);
    rob_branch_commit = 1'b1;
    rob_branch_pc     = 32'h40;
    rob_branch_taken  = 1'b1;
    refetch_beq(1'b0);

    // Mispredict while a fetch is outstanding: stale return must be dropped.
    issue_ready = 1'b0;
    redirect(32'h80);
    exp_push(NOP, 32'h80, 1'b0);
    fetch_n(1);
    mem_lat = 3;
    req_wait(1);
    redirect(32'h100);
    mem_lat = 0;
    exp_push(NOP, 32'h100, 1'b0);
    fetch_n(1);
    chk("redirect_mem_pc", last_req_pc, 32'h100);
    drain();

    // Mispredict in the same cycle as mem_done and a pop.
    issue_ready = 1'b0;
    redirect(32'h200);
    exp_push(NOP, 32'h200, 1'b0);
    fetch_n(1);
    req_wait(1);
    issue_ready = 1'b1;
    redirect(32'h300);
    exp_push(NOP, 32'h300, 1'b0);
    fetch_n(1);
    chk("coincide_mem_pc", last_req_pc, 32'h300);
    drain();

    // Reset while waiting on memory.
    issue_ready = 1'b0;
    exp_push(NOP, 32'h304, 1'b0);
    fetch_n(1);
    mem_lat = 3;
    req_wait(1);
    rst_in = 1'b1;
    tick(1);
    rst_in = 1'b0;
    exp_q.delete();
    @(negedge clk_in);
    chk("wait_rst_issue_valid", 32'(issue_valid), 32'd0);
    chk("wait_rst_mem_req", 32'(mem_req), 32'd0);
    chk("wait_rst_roll_back", 32'(roll_back_out), 32'd0);
    chk("wait_rst_mem_pc", mem_pc, 32'h0);
    @(posedge clk_in);
    #1;
    tick(5);
    @(negedge clk_in);
    chk("stale_done_ignored", 32'(issue_valid), 32'd0);
    @(posedge clk_in);
    #1;
    mem_lat = 0;
    exp_push(NOP, 32'h0, 1'b0);
    fetch_n(1);
    chk("post_rst_mem_pc", last_req_pc, 32'h0);
    drain();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
